priority_decoder: RTL
=====================

PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the accepted-transfer counter.
REQ-003 The ports SHALL be as follows, in this order:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers a code.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  3  priority index 0..7.
- in_mask  input  1  0 = one-hot output; 1 = thermometer output.
- in_none  input  1  1 = "no request" token; in_code is ignored.
- out_valid  output  1  D holds a decoded word.
- out_ready  input  1  downstream accepts D this cycle.
- D  output  8  decoded request word.
- out_none  output  1  the current word is a "no request" token.
- dec_count  output  CNT_W  saturating count of output handshakes.

Function
REQ-004 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising clk edge.
REQ-005 An output transfer SHALL occur when out_valid and out_ready are both 1 on a rising clk edge.
REQ-006 The decoded word SHALL be computed from in_code, in_mask and in_none at the input transfer, as follows:
- in_none=1: D=8'h00 and out_none=1.
- in_mask=0: D has only bit in_code set.
- in_mask=1: D has bits [in_code:0] set.
REQ-007 Decoded words SHALL be held in a 2-entry FIFO with occupancy states EMPTY, ONE and FULL.
REQ-008 The occupancy state SHALL change as follows (no change in any other case):
- EMPTY -> ONE on a push.
- ONE -> FULL on a push without a pop.
- ONE -> EMPTY on a pop without a push.
- ONE stays ONE on a simultaneous push and pop.
- FULL -> ONE on a pop.
REQ-009 in_ready SHALL be 1 exactly when the state is not FULL, and SHALL be driven from registered state only, with no combinational path from out_ready.
REQ-010 In FULL, a simultaneous pop SHALL NOT admit a push in the same cycle; in_ready rises on the following cycle.
REQ-011 out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-012 D and out_none SHALL show the oldest entry.
REQ-013 Latency SHALL be one cycle: a word pushed at edge N is visible on D after edge N when the FIFO was EMPTY.
REQ-014 When out_valid=1 and out_ready=0, D and out_none SHALL hold stable.
REQ-015 With out_ready held at 1, the block SHALL sustain one transfer per cycle.
REQ-016 Words SHALL leave in acceptance order, with none lost or duplicated.
REQ-017 dec_count SHALL increment by 1 on each output transfer and SHALL saturate at all-ones, with no wrap-around.
REQ-018 None-token transfers SHALL also be counted in dec_count.
REQ-019 in_code, in_mask and in_none SHALL be ignored when no input transfer occurs.
REQ-020 While the state is EMPTY, D SHALL read 8'h00 and out_none SHALL read 0.

Reset
REQ-021 While rst=1 at a clock edge, the state SHALL go to EMPTY and all FIFO storage SHALL clear to 0.
REQ-022 While rst=1 at a clock edge, dec_count SHALL clear to 0.
REQ-023 After a reset edge, the outputs SHALL be: out_valid=0, in_ready=1, D=8'h00, out_none=0, dec_count=0.
REQ-024 Reset SHALL take priority over a simultaneous push or pop; entries in flight SHALL be discarded and SHALL NOT be counted.

Structure
REQ-025 A shared package pdec_pkg SHALL hold the following:
- the occupancy-state enum {EMPTY, ONE, FULL};
- typedef code_t (3 bits);
- typedef word_t (8 bits);
- constant NONE_WORD = 8'h00;
- a decode function of (code, mask) returning word_t.
REQ-026 The 2-entry FIFO SHALL be a sub-module pdec_skid_fifo, parameterised on entry width, which stores {none, word} and contains the state machine.
REQ-027 The top level SHALL contain only the decode function and the counter.

Verification
REQ-028 Reset and decode check: assert rst; push code=5 with mask=0 while out_ready=1 -> out_valid=0 and in_ready=1 during reset; one cycle after the push, D=8'h20, out_none=0, dec_count=1.
REQ-029 Mask mode: push code=3 with mask=1, then code=7 with mask=1, then code=0 with mask=0 -> D=8'h0F, then 8'hFF, then 8'h01, in that order.
REQ-030 Backpressure: with out_ready=0, push codes 1, 2, 4 on consecutive cycles -> in_ready=0 after the second push, the third code is not accepted, and D holds 8'h02 stable.
REQ-031 Backpressure release: after the REQ-030 sequence, set out_ready=1 -> output order is 8'h02 then 8'h04; in_ready rises one cycle after the first pop.
REQ-032 None token: push in_none=1 with code=6 -> D=8'h00, out_none=1, and dec_count increments.
REQ-033 Saturation and mid-operation reset: with CNT_W=4, stream 20 transfers -> dec_count stops at 4'hF. Then pulse rst while FULL -> the next cycle shows out_valid=0, dec_count=0 and in_ready=1.

Source files
------------

// File: rtl/pdec_pkg.sv
// Shared types, constants and the priority decode function for the
// priority decoder slice.
package pdec_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef logic [2:0] code_t;
  typedef logic [7:0] word_t;

  localparam word_t NONE_WORD = 8'h00;
  // FIFO entries carry {none, word}
  localparam int ENTRY_W = 9;

  // mask=0: one-hot at code; mask=1: thermometer, bits [code:0] set
  function automatic word_t decode(code_t code, logic mask);
    word_t w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[i] = mask ? (i <= int'(code)) : (i == int'(code));
    end
    return w;
  endfunction

endpackage

// File: rtl/pdec_skid_fifo.sv
// Two-entry FIFO with an EMPTY/ONE/FULL occupancy state machine; the head
// register always holds the oldest entry and reads zero when empty.
module pdec_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  import pdec_pkg::*;

  // Handshake: a push happens when push_valid && push_ready at a rising edge,
  // a pop when pop_valid && pop_ready; neither ready depends on the other side.
  occ_t         state;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign push = push_valid && push_ready;
  assign pop  = pop_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= push_data;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail  <= push_data;
              state <= FULL;
            end
            2'b01: begin
              head  <= '0;
              state <= EMPTY;
            end
            2'b11: head <= push_data;
            default: ;
          endcase
        end
        FULL: begin
          // push_ready is low here, so a pop never coincides with a push
          if (pop) begin
            head  <= tail;
            tail  <= '0;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign push_ready = (state != FULL);
  assign pop_valid  = (state != EMPTY);
  assign pop_data   = head;

endmodule

// File: rtl/priority_decoder.sv
// Priority decoder: decodes a 3-bit code into a one-hot or thermometer word,
// buffers it in a 2-entry FIFO and counts output handshakes (saturating).
module priority_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  input  logic             in_mask,
  input  logic             in_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       D,
  output logic             out_none,
  output logic [CNT_W-1:0] dec_count
);
  import pdec_pkg::*;

  logic [ENTRY_W-1:0] din;
  logic [ENTRY_W-1:0] dout;

  assign din = in_none ? {1'b1, NONE_WORD} : {1'b0, decode(in_code, in_mask)};

  pdec_skid_fifo #(.W(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (din),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (dout)
  );

  assign D        = dout[7:0];
  assign out_none = dout[8];

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_count <= '0;
    end else if (out_valid && out_ready && (dec_count != {CNT_W{1'b1}})) begin
      dec_count <= dec_count + 1'b1;
    end
  end

endmodule
